// File: rtl/serial_receiver.sv
// Deserialises a tick-paced, soc/en framed serial word (MSB first) into a parallel word with a one-cycle valid strobe.
// Optional even-parity bit after the data bits when RX_PARITY_EN is defined.
module serial_receiver #(
   parameter int WIDTH = 12,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             soc,
   input  logic             en,
   input  logic             sdi,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             busy,
   output logic             frame_err,
   output logic             parity_err
);

`ifdef RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, WAIT, SHIFT, DONE, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;
`endif

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [WIDTH-1:0]   sh_q, sh_d, sh_sft, data_d;
   logic               ferr_d;
`ifdef RX_PARITY_EN
   logic               perr_q, perr_d;
`endif

   // Truncating cast drops the oldest bit as the new one enters at the LSB
   assign sh_sft  = WIDTH'({sh_q, sdi});
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sh_q      <= '0;
         data      <= '0;
         frame_err <= 1'b0;
`ifdef RX_PARITY_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         data      <= data_d;
         frame_err <= ferr_d;
`ifdef RX_PARITY_EN
         perr_q    <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      data_d  = data;
      ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
      perr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (soc) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            // soc outranks a coincident tick: restart without sampling
            if (soc) begin
               ferr_d = 1'b1;
               cnt_d  = '0;
            end else if (tick && en) begin
               sh_d    = sh_sft;
               cnt_d   = CNT_W'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (soc) begin
               ferr_d  = 1'b1;
               cnt_d   = '0;
               state_d = WAIT;
            end else if (tick) begin
               if (en) begin
                  sh_d  = sh_sft;
                  cnt_d = cnt_inc;
                  if (cnt_inc == LAST) begin
`ifdef RX_PARITY_EN
                     state_d = PAR;
`else
                     state_d = DONE;
                     data_d  = sh_sft;
`endif
                  end
               end else begin
                  ferr_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
`ifdef RX_PARITY_EN
         PAR: begin
            if (soc) begin
               ferr_d  = 1'b1;
               cnt_d   = '0;
               state_d = WAIT;
            end else if (tick) begin
               if (!en) begin
                  ferr_d  = 1'b1;
                  state_d = IDLE;
               end else if (^{sh_q, sdi}) begin
                  perr_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  data_d  = sh_q;
                  state_d = DONE;
               end
            end
         end
`endif
         DONE: begin
            if (soc) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign valid = (state_q == DONE);
`ifdef RX_PARITY_EN
   assign busy       = (state_q == WAIT) || (state_q == SHIFT) || (state_q == PAR);
   assign parity_err = perr_q;
`else
   assign busy       = (state_q == WAIT) || (state_q == SHIFT);
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver (WIDTH=12): nominal, back-to-back, aborts, async reset, optional parity.
module tb_serial_receiver;
   localparam int W = 12;

   logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, soc = 1'b0, en = 1'b0, sdi = 1'b0;
   logic [W-1:0] data;
   logic valid, busy, frame_err, parity_err;

   int errs = 0, nchk = 0, fcnt = 0, pcnt = 0;
   logic [W-1:0] vq[$];
   logic busy_v = 1'b1;

   always #5 clk = ~clk;

   serial_receiver #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .soc(soc), .en(en), .sdi(sdi),
      .data(data), .valid(valid), .busy(busy), .frame_err(frame_err), .parity_err(parity_err)
   );

   // pulse monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (valid) begin
         vq.push_back(data);
         busy_v = busy;
      end
      if (frame_err) fcnt++;
      if (parity_err) pcnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_soc();
      soc = 1'b1;
      cyc();
      soc = 1'b0;
   endtask

   task automatic send_bits(input logic [W-1:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1; en = 1'b1; sdi = w[W-1-i];
         cyc();
         tick = 1'b0;
         cyc();
      end
   endtask

   // full frame from WAIT; s asserts soc during the DONE cycle
   task automatic send_word(input logic [W-1:0] w, input logic s, input logic pb);
      for (int i = W-1; i >= 0; i--) begin
         tick = 1'b1; en = 1'b1; sdi = w[i];
         cyc();
         tick = 1'b0;
         if (i != 0) cyc();
      end
      sdi = pb;
`ifdef RX_PARITY_EN
      cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
`endif
      soc = s;
      cyc();
      soc = 1'b0;
      en  = 1'b0;
      cyc();
   endtask

   initial begin
      cyc(); cyc();
      chk("rst_data",  32'(data), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_ferr",  32'(frame_err), 32'h0);
      rst_n = 1'b1;
      cyc();

      // nominal frame
      pulse_soc();
      chk("wait_busy", 32'(busy), 32'h1);
      send_word(12'hA5C, 1'b0, ^12'hA5C);
      chk("nom_nvalid", 32'(vq.size()), 32'd1);
      chk("nom_vdata", 32'(vq[0]), 32'hA5C);
      chk("nom_busy_at_valid", 32'(busy_v), 32'h0);
      chk("nom_data", 32'(data), 32'hA5C);
      chk("nom_idle_busy", 32'(busy), 32'h0);
      chk("nom_ferr", 32'(fcnt), 32'd0);

      // back-to-back, soc during DONE of the first
      pulse_soc();
      send_word(12'hFFF, 1'b1, ^12'hFFF);
      chk("b2b_busy", 32'(busy), 32'h1);
      send_word(12'h001, 1'b0, ^12'h001);
      chk("b2b_nvalid", 32'(vq.size()), 32'd3);
      chk("b2b_first", 32'(vq[1]), 32'hFFF);
      chk("b2b_second", 32'(vq[2]), 32'h001);
      chk("b2b_ferr", 32'(fcnt), 32'd0);

      // en drops on the 7th tick
      pulse_soc();
      send_bits(12'hABC, 6);
      tick = 1'b1; en = 1'b0;
      cyc();
      tick = 1'b0;
      cyc();
      chk("drop_ferr", 32'(fcnt), 32'd1);
      chk("drop_nvalid", 32'(vq.size()), 32'd3);
      chk("drop_data", 32'(data), 32'h001);
      chk("drop_busy", 32'(busy), 32'h0);

      // soc coincident with the 5th tick
      pulse_soc();
      send_bits(12'hFFF, 4);
      tick = 1'b1; soc = 1'b1; en = 1'b1; sdi = 1'b1;
      cyc();
      tick = 1'b0; soc = 1'b0;
      cyc();
      chk("socab_ferr", 32'(fcnt), 32'd2);
      chk("socab_busy", 32'(busy), 32'h1);
      send_word(12'h3C3, 1'b0, ^12'h3C3);
      chk("socab_nvalid", 32'(vq.size()), 32'd4);
      chk("socab_data", 32'(data), 32'h3C3);

      // asynchronous reset after 6 bits
      pulse_soc();
      send_bits(12'h123, 6);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data", 32'(data), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_valid", 32'(valid), 32'h0);
      chk("arst_ferr", 32'(frame_err), 32'h0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      pulse_soc();
      send_word(12'h123, 1'b0, ^12'h123);
      chk("arst_nvalid", 32'(vq.size()), 32'd5);
      chk("arst_newdata", 32'(data), 32'h123);
      chk("arst_ferr_cnt", 32'(fcnt), 32'd2);

`ifdef RX_PARITY_EN
      pulse_soc();
      send_word(12'h0F0, 1'b0, 1'b0);
      chk("par_ok_nvalid", 32'(vq.size()), 32'd6);
      chk("par_ok_data", 32'(data), 32'h0F0);
      chk("par_ok_perr", 32'(pcnt), 32'd0);
      pulse_soc();
      send_word(12'h0F0, 1'b0, 1'b1);
      chk("par_bad_perr", 32'(pcnt), 32'd1);
      chk("par_bad_nvalid", 32'(vq.size()), 32'd6);
      chk("par_bad_data", 32'(data), 32'h0F0);
      pulse_soc();
      send_word(12'h0F1, 1'b0, 1'b0);
      chk("par_bad2_perr", 32'(pcnt), 32'd2);
      chk("par_bad2_data", 32'(data), 32'h0F0);
`else
      chk("nopar_perr", 32'(pcnt), 32'd0);
      chk("nopar_pin", 32'(parity_err), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end
endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Receive-side counterpart of the Transmission block.
- Deserialises the tick-paced serial frame that Transmission frames with soc/en into a parallel word, then presents it with a one-cycle valid strobe.
- Sits in the SineWave datapath at the far end of the serial link, on the same 100 MHz clk and the same TickCounter tick.

Parameters:
- WIDTH, 12, data bits per frame, MSB first; legal range 2..32.
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, 100 MHz, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  bit-rate strobe, one clk cycle wide.
- soc  input  1  start-of-frame pulse, one clk cycle wide.
- en  input  1  frame-active level; high while bits are on the line.
- sdi  input  1  serial data in.
- data  output  WIDTH  last correctly received word.
- valid  output  1  one-cycle pulse when data has been updated.
- busy  output  1  high while in WAIT or SHIFT.
- frame_err  output  1  one-cycle pulse when a frame is aborted.
- parity_err  output  1  one-cycle parity-failure pulse; tied 0 unless RX_PARITY_EN is defined.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bit count=0, shift register=0, data=0. valid, busy, frame_err and parity_err are all 0. Reset mid-frame discards the partial word.
- All inputs are synchronous to clk; no input synchronisers.
- FSM states: IDLE, WAIT, SHIFT, DONE.
- IDLE: soc=1 -> WAIT, bit count cleared. Ignores tick, en and sdi.
- WAIT:
  - tick=1 and en=1 -> sample sdi into shift register LSB (left shift), count=1, go to SHIFT.
  - tick=1 and en=0 -> stay in WAIT; the frame has not started.
- SHIFT, on each tick:
  - en=1 -> shift in sdi, count+1.
  - If the count reaches WIDTH on this tick -> DONE (or PAR, see optional feature).
  - en=0 on a tick before WIDTH bits -> pulse frame_err, go to IDLE, data unchanged.
- DONE, one cycle: data <= shift register, valid=1, then go to IDLE.
- Latency: valid is high in the clk cycle immediately after the edge that sampled the last bit.
- soc while in WAIT or SHIFT: abort the current frame, pulse frame_err, restart in WAIT with count=0. soc outranks a simultaneous tick, so that tick is not sampled.
- soc while in DONE: DONE completes normally (valid pulses), then the FSM goes to WAIT instead of IDLE.
- busy=1 in WAIT, SHIFT and PAR; 0 in IDLE and DONE.
- Without a tick, every state except DONE holds indefinitely; there is no timeout.
- data holds its value between frames; valid is never asserted for an aborted frame.
- Bit order: first sampled bit becomes data[WIDTH-1].

Optional Feature:
- Macro: RX_PARITY_EN.
- When defined:
  - An extra state PAR follows the WIDTH-th bit.
  - The next tick with en=1 samples an even-parity bit (XOR of data bits plus parity bit = 0).
  - Match -> DONE (data updated, valid pulses).
  - Mismatch -> parity_err pulses, data unchanged, FSM goes to IDLE.
  - en=0 on that tick -> frame_err and IDLE.
  - soc during PAR behaves as in SHIFT.
- When not defined: there is no PAR state, parity_err is tied 0, and the frame is exactly WIDTH ticks.

Test Plan:
- Nominal frame, WIDTH=12: soc, then 12 ticks carrying 0xA5C MSB first with en=1 -> valid pulses once, data=0xA5C, busy falls with valid, frame_err=0.
- Back-to-back frames: 0xFFF then 0x001 with soc asserted during DONE of the first -> two valid pulses with data=0xFFF then 0x001, no frame_err.
- Early en drop: en goes low at the 7th tick -> frame_err pulse, no valid, data keeps its previous value, FSM returns to IDLE.
- soc on the same cycle as the 5th tick -> frame_err pulse, that tick is not sampled; a following full frame of 0x3C3 -> data=0x3C3.
- rst_n=0 asserted asynchronously mid-frame after 6 bits -> all outputs 0 immediately; after release, a full frame of 0x123 -> data=0x123.
- With RX_PARITY_EN defined: frame 0x0F0 with parity bit 0 -> valid, data=0x0F0; same frame with parity bit 1 -> parity_err pulse, no valid, data unchanged.
